// File: rtl/add7_pkg.sv
// Shared types and sizes for the 7-operand add feeder.
package add7_pkg;

  localparam int WIDTH = 32;
  localparam int N_OPS = 7;
  localparam int IDX_W = $clog2(N_OPS);

  typedef enum logic [1:0] {
    COLLECT,
    START,
    WAIT,
    OUTPUT
  } feeder_state_t;

  typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/add7_operand_buf.sv
// Operand bank: N_OPS words written one at a time by index, read out as one flat vector.
module add7_operand_buf #(
  parameter int WIDTH = add7_pkg::WIDTH,
  parameter int N_OPS = add7_pkg::N_OPS,
  parameter int IDX_W = add7_pkg::IDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [N_OPS*WIDTH-1:0] ops
);

  logic [N_OPS-1:0][WIDTH-1:0] bank;

  // Compare against each slot so an out-of-range index can never write.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank <= '0;
    end else begin
      for (int i = 0; i < N_OPS; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          bank[i] <= wr_data;
        end
      end
    end
  end

  assign ops = bank;

endmodule

// File: rtl/add7_feeder.sv
// Streams N_OPS operands into the add kernel, pulses start, waits for done, streams the result.
// Optional done-wait watchdog enabled with `define ADD7_FEEDER_TIMEOUT_EN.
module add7_feeder #(
  parameter int WIDTH          = add7_pkg::WIDTH,
  parameter int N_OPS          = add7_pkg::N_OPS,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   k_start,
  output logic [N_OPS*WIDTH-1:0] k_ops,
  input  logic                   k_done,
  input  logic [WIDTH-1:0]       k_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   busy,
  output logic                   k_timeout
);

  import add7_pkg::*;

  localparam int IDX_BITS = (N_OPS > 1) ? $clog2(N_OPS) : 1;

  // Both streams are valid/ready: a beat transfers on a clock edge where valid and ready
  // are both high; valid is held with stable data until that edge.

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("add7_feeder: TIMEOUT_CYCLES must be at least 1");
  end

  feeder_state_t       state;
  logic [IDX_BITS-1:0] idx;
  logic                wr_en;

  assign in_ready = (state == COLLECT);
  assign busy     = (state != COLLECT);
  assign wr_en    = in_valid && in_ready;

  add7_operand_buf #(
    .WIDTH (WIDTH),
    .N_OPS (N_OPS),
    .IDX_W (IDX_BITS)
  ) u_operand_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_data (in_data),
    .ops     (k_ops)
  );

`ifdef ADD7_FEEDER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;
  assign k_timeout = timeout_q;
`else
  assign k_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      idx       <= '0;
      k_start   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef ADD7_FEEDER_TIMEOUT_EN
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      k_start <= 1'b0;
      case (state)
        COLLECT: begin
          if (wr_en) begin
            if (idx == IDX_BITS'(N_OPS - 1)) begin
              idx     <= '0;
              state   <= START;
              k_start <= 1'b1;
            end else begin
              idx <= idx + IDX_BITS'(1);
            end
          end
        end
        START: begin
          state <= WAIT;
`ifdef ADD7_FEEDER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        // The kernel clears done on the start edge, so any done seen here is for this call.
        WAIT: begin
          if (k_done) begin
            out_data  <= k_result;
            out_valid <= 1'b1;
            state     <= OUTPUT;
          end
`ifdef ADD7_FEEDER_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_q <= 1'b1;
            out_data  <= '0;
            out_valid <= 1'b1;
            state     <= OUTPUT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_add7_feeder.sv
// Bench for add7_feeder: behavioural kernel, sum-of-operands reference, per-scenario tasks.
`timescale 1ns/1ps
module tb_add7_feeder;
  import add7_pkg::*;

  localparam int T_CYC = 64;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  in_valid = 1'b0;
  logic  out_ready = 1'b0;
  logic  k_done = 1'b0;
  word_t in_data = '0;
  word_t k_result = '0;
  logic  in_ready, k_start, out_valid, busy, k_timeout;
  logic [N_OPS*WIDTH-1:0] k_ops;
  word_t out_data;

  add7_feeder #(
    .WIDTH          (WIDTH),
    .N_OPS          (N_OPS),
    .TIMEOUT_CYCLES (T_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .k_start   (k_start),
    .k_ops     (k_ops),
    .k_done    (k_done),
    .k_result  (k_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .k_timeout (k_timeout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "bench stalled");
  end

  // ---------------- kernel model and monitors ----------------
  word_t exp_q[$];
  word_t cur_words[N_OPS];
  int    start_cnt = 0;
  int    start_cyc = 0;
  int    ov_cycles = 0;
  int    kern_lat = 8;
  bit    kern_hang = 1'b0;
  int    kern_cnt = 0;
  bit    kern_busy = 1'b0;
  word_t kern_sum = '0;
  logic [N_OPS*WIDTH-1:0] ops_seen = '0;

  always @(negedge clk) begin
    if (k_start) begin
      start_cnt++;
      start_cyc = cyc;
      ops_seen  = k_ops;
      k_done    = 1'b0;
      kern_sum  = '0;
      for (int i = 0; i < N_OPS; i++) kern_sum += k_ops[i*WIDTH +: WIDTH];
      kern_cnt  = kern_lat;
      kern_busy = !kern_hang;
    end else if (kern_busy) begin
      if (kern_cnt <= 1) begin
        k_done    = 1'b1;
        k_result  = kern_sum;
        kern_busy = 1'b0;
      end else begin
        kern_cnt--;
      end
    end
    if (out_valid) ov_cycles++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_words(input bit gap, output int guard);
    guard = 0;
    for (int i = 0; i < N_OPS; i++) begin
      in_valid = 1'b1;
      in_data  = cur_words[i];
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      @(negedge clk);
      if (gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  // One full call: operands from cur_words, result expected from the scoreboard queue.
  task automatic do_call(input bit gap, input int hold, input int lat);
    word_t sum = '0;
    word_t exp;
    logic [N_OPS*WIDTH-1:0] exp_ops = '0;
    int s0, ov0, guard, stuck, unstable;
    for (int i = 0; i < N_OPS; i++) begin
      sum += cur_words[i];
      exp_ops[i*WIDTH +: WIDTH] = cur_words[i];
    end
    exp_q.push_back(sum);
    kern_lat  = lat;
    out_ready = (hold == 0);
    s0  = start_cnt;
    ov0 = ov_cycles;
    send_words(gap, guard);
    total++;
    if (guard >= 50) begin
      bad++;
      $display("FAIL in_accept: stalled %0d cycles, required under 50", guard);
    end
    guard = 0;
    stuck = 0;
    while (!out_valid && guard < 200) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) stuck++;
      @(negedge clk);
      guard++;
    end
    total++;
    if (guard >= 200) begin
      bad++;
      $display("FAIL out_wait: out_valid absent after %0d cycles, required within 200", guard);
    end
    total++;
    if (stuck != 0) begin
      bad++;
      $display("FAIL busy_in_call: %0d cycles with in_ready=1 or busy=0, required 0", stuck);
    end
    exp = exp_q.pop_front();
    total++;
    if (out_data !== exp) begin
      bad++;
      $display("FAIL result: out_data=%h required %h", out_data, exp);
    end
    unstable = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== exp) unstable++;
    end
    total++;
    if (unstable != 0) begin
      bad++;
      $display("FAIL out_hold: %0d unstable cycles while stalled, required 0", unstable);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL after_accept: out_valid=%b in_ready=%b busy=%b required 0 1 0",
               out_valid, in_ready, busy);
    end
    total++;
    if (ov_cycles - ov0 != hold + 1) begin
      bad++;
      $display("FAIL out_valid_len: %0d cycles, required %0d", ov_cycles - ov0, hold + 1);
    end
    total++;
    if (start_cnt - s0 != 1) begin
      bad++;
      $display("FAIL start_pulses: %0d, required 1", start_cnt - s0);
    end
    total++;
    if (ops_seen !== exp_ops) begin
      bad++;
      $display("FAIL k_ops: got %h required %h", ops_seen, exp_ops);
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (out_valid !== 1'b0 || k_start !== 1'b0 || out_data !== '0 || k_ops !== '0 ||
        k_timeout !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s: ov=%b ks=%b od=%h ops_nz=%b to=%b ir=%b busy=%b required 0 0 0 0 0 1 0",
               tag, out_valid, k_start, out_data, (k_ops != '0), k_timeout, in_ready, busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int s0 = start_cnt;
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("after_reset_release");
    total++;
    if (start_cnt != s0) begin
      bad++;
      $display("FAIL reset_start: %0d pulses during reset, required 0", start_cnt - s0);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < N_OPS; i++) cur_words[i] = word_t'(i + 1);
    do_call(1'b0, 0, 8);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < N_OPS; i++) cur_words[i] = 32'hFFFF_FFFF;
    do_call(1'b0, 0, 8);
  endtask

  task automatic test_toggle_valid();
    for (int i = 0; i < N_OPS; i++) cur_words[i] = word_t'(10 * (i + 1));
    do_call(1'b1, 0, 8);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N_OPS; i++) cur_words[i] = $urandom;
    do_call(1'b0, 5, 8);
  endtask

  task automatic test_reset_mid_call();
    int s0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = word_t'(100 + i);
      @(negedge clk);
    end
    s0 = start_cnt;
    in_data = 32'd103;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check_reset_values("mid_call_reset");
    total++;
    if (start_cnt != s0) begin
      bad++;
      $display("FAIL mid_reset_start: %0d pulses, required 0", start_cnt - s0);
    end
    for (int i = 0; i < N_OPS; i++) cur_words[i] = 32'd2;
    do_call(1'b0, 0, 8);
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N_OPS; i++) cur_words[i] = $urandom;
      do_call(1'b0, 0, $urandom_range(1, 4));
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N_OPS; i++) cur_words[i] = $urandom;
      do_call(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(1, 12));
    end
  endtask

  task automatic test_timeout();
    int guard;
    int ovc;
    for (int i = 0; i < N_OPS; i++) cur_words[i] = $urandom;
    kern_hang = 1'b1;
    out_ready = 1'b0;
    send_words(1'b0, guard);
`ifdef ADD7_FEEDER_TIMEOUT_EN
    guard = 0;
    while (!out_valid && guard < T_CYC + 50) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (!out_valid) begin
      bad++;
      $display("FAIL timeout_fire: out_valid=0 after %0d cycles, required 1", guard);
    end
    total++;
    if (cyc - start_cyc != T_CYC + 1) begin
      bad++;
      $display("FAIL timeout_latency: %0d cycles after start, required %0d",
               cyc - start_cyc, T_CYC + 1);
    end
    total++;
    if (out_data !== '0 || k_timeout !== 1'b1) begin
      bad++;
      $display("FAIL timeout_output: out_data=%h k_timeout=%b required 0 1", out_data, k_timeout);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (k_timeout !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL timeout_sticky: k_timeout=%b out_valid=%b required 1 0", k_timeout, out_valid);
    end
`else
    ovc = 0;
    repeat (2 * T_CYC) begin
      @(negedge clk);
      if (out_valid) ovc++;
    end
    total++;
    if (ovc != 0 || k_timeout !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL no_timeout: out_valid cycles=%0d k_timeout=%b busy=%b required 0 0 1",
               ovc, k_timeout, busy);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    kern_hang = 1'b0;
    check_reset_values("reset_after_timeout");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_toggle_valid();
    test_backpressure();
    test_reset_mid_call();
    test_back_to_back();
    test_random();
    test_timeout();
    test_sequential();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d results left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
